rr_mux_reg: RTL

- N-channel, parametrised successor to the fixed 2:1/3:1 selectors.
- Arbitrates among CHANNELS valid/ready sources and forwards one word per cycle into a single registered output stage. The output stage holds its value under backpressure.
- Two arbitration modes:
  - Fixed priority, where the highest index wins, as in the 3:1 selector.
  - Round-robin.
- Sits between multiple address/word producers and a single downstream consumer (counter/register load path).

---
 rtl/rr_mux_reg.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rr_mux_reg.sv
// rr_mux_reg
//
// Purpose:
//   Selects one of CHANNELS valid/ready word sources each cycle and loads the
//   chosen word into a single registered output stage. The output stage is a
//   one-entry buffer. It holds its word while the consumer stalls, and it can
//   be drained and reloaded on the same edge, so it sustains one word per
//   cycle. Arbitration is either fixed priority, where the highest index wins,
//   or round-robin, which starts the search just after the last channel served.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   di        packed channel words; channel i is di[i*DATA_LENGTH +: DATA_LENGTH]
//   di_valid  per-channel word-present flag
//   di_ready  per-channel accept strobe (at most one bit high)
//   do_data   registered output word
//   do_sel    index of the channel that supplied do_data
//   do_valid  output register holds an unconsumed word
//   do_ready  consumer accepts do_data this cycle

`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif

module rr_mux_reg #(
  parameter int DATA_LENGTH = `DATA_LENGTH,
  parameter int CHANNELS    = 4,
  parameter int SEL_WIDTH   = $clog2(CHANNELS),
  parameter int ROUND_ROBIN = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CHANNELS*DATA_LENGTH-1:0] di,
  input  logic [CHANNELS-1:0]             di_valid,
  output logic [CHANNELS-1:0]             di_ready,
  output logic [DATA_LENGTH-1:0]          do_data,
  output logic [SEL_WIDTH-1:0]            do_sel,
  output logic                            do_valid,
  input  logic                            do_ready
);

  logic                   load_en;
  logic [SEL_WIDTH-1:0]   last;
  logic [SEL_WIDTH-1:0]   grant_idx;
  logic                   any_grant;
  logic [CHANNELS-1:0]    grant;
  logic [DATA_LENGTH-1:0] sel_word;
  int                     idx;

  // The output register can take a new word when it is empty or when its
  // current word leaves on this edge.
  assign load_en = !do_valid | do_ready;

  // Arbitration picks at most one valid channel. The grant is forced to zero
  // during reset so that no ready strobe can leak out while the block is held.
  // In round-robin mode the search starts at last+1 and wraps at CHANNELS,
  // not at 2^SEL_WIDTH. An index outside the channel range is therefore never
  // produced. In fixed-priority mode the ascending loop lets the highest
  // valid index overwrite any lower one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    if (!reset) begin
      if (ROUND_ROBIN != 0) begin
        for (int k = 1; k <= CHANNELS; k++) begin
          idx = int'(last) + k;
          if (idx >= CHANNELS) begin
            idx = idx - CHANNELS;
          end
          if (!any_grant && di_valid[SEL_WIDTH'(idx)]) begin
            any_grant = 1'b1;
            grant_idx = SEL_WIDTH'(idx);
          end
        end
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (di_valid[SEL_WIDTH'(i)]) begin
            any_grant = 1'b1;
            grant_idx = SEL_WIDTH'(i);
          end
        end
      end
    end
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Steer the granted channel's word toward the output register.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_WIDTH'(i)) begin
        sel_word = di[i*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  // A channel sees ready only when it holds the grant and the output
  // register can accept. A stalled consumer therefore blocks every input.
  assign di_ready = grant & {CHANNELS{load_en}};

  // Output register and round-robin pointer.
  // The pointer moves only on an accepted transfer. After reset it points at
  // the last channel, so channel 0 is searched first. When the register can
  // load but no channel is valid, the register empties. do_data and do_sel
  // keep their previous values in that case, which keeps them stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      do_data  <= '0;
      do_sel   <= '0;
      do_valid <= 1'b0;
      last     <= SEL_WIDTH'(CHANNELS - 1);
    end else if (load_en) begin
      if (any_grant) begin
        do_data  <= sel_word;
        do_sel   <= grant_idx;
        do_valid <= 1'b1;
        if (ROUND_ROBIN != 0) begin
          last <= grant_idx;
        end
      end else begin
        do_valid <= 1'b0;
      end
    end
  end

endmodule
